mdu: RTL
========

# mdu

Multiply/divide unit in the E stage, the sequential companion of the combinational ALU: it takes the same `SRCA`/`SRCB` operands and implements MIPS `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo`. Results land in the architectural HI/LO registers after a fixed multi-cycle latency. A `busy` handshake lets the hazard unit stall dependent instructions in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `req`  in  1  E-stage instruction is a valid MDU op (low for bubbles and flushed slots).
- `MDUop`  in  4  operation code; encodings come from `mdu_pkg`.
- `SRCA`  in  32  rs operand.
- `SRCB`  in  32  rt operand.
- `start`  out  1  combinational: `req` && (`MDUop` is mult/multu/div/divu) && !`busy`.
- `busy`  out  1  registered; high while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `MDUresult`  out  32  combinational: `HI` for MFHI, `LO` for MFLO, 0 otherwise.

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 behave as NONE.
- States:
  - IDLE (`busy`=0): `start` latches the pending result and loads the counter with `MULT_CYCLES` or `DIV_CYCLES`, then goes to RUN.
  - RUN (`busy`=1): the counter decrements once per cycle. When it reaches 1, the next edge writes the pending HI/LO, clears `busy` and returns to IDLE.
- The result is computed from the operands as sampled on the accept edge. Later changes on `SRCA`/`SRCB` have no effect.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (`SRCB`=0): the operation still occupies `DIV_CYCLES` busy cycles; HI and LO are left unchanged at completion.
- MTHI/MTLO: when `req` && !`busy`, the next edge writes `SRCA` into HI or LO.
- While `busy`=1, every `req` (mult/div/mt*) is ignored and HI/LO are untouched. The hazard unit is responsible for stalling MDU instructions while `busy`||`start`.
- MFHI/MFLO during `busy` return the old HI/LO; stalling is upstream's job.

## Timing
- Reset (async, `reset`=0): `busy`=0, HI=0, LO=0, counter=0, pending registers=0, state IDLE. `start` and `MDUresult` then follow from the inputs.
- Accept at edge E0: `busy` is high from E0 through the edge before E0+N, where N is the latency parameter. HI/LO update at edge E0+N; `busy` falls at that same edge.
- A new `start` is accepted in the cycle right after `busy` falls (back-to-back operations are allowed).
- Reset asserted mid-operation aborts it: no HI/LO commit, and the unit is idle once reset is released.
- `req` with `MDUop`=NONE or an undefined code never changes state.

## Structure
- `mdu_pkg` holds:
  - op encodings as a 4-bit enum `mdu_op_t`;
  - default latencies `MULT_CYCLES_DEF`=5 and `DIV_CYCLES_DEF`=10;
  - the `mdu_state_t` {IDLE, RUN} typedef.
- Result generation (signed/unsigned 64-bit multiply, divide, div-by-zero and overflow handling) lives in the combinational sub-module `mdu_calc`, with ports `SRCA`, `SRCB`, `MDUop` → `hi_next`, `lo_next`, `div_zero`.
- `mdu` holds only the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT with SRCA=0xFFFFFFFE (−2), SRCB=3: `busy` is high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV with SRCA=0xFFFFFFF9 (−7), SRCB=2: 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with SRCA=7, SRCB=2 gives LO=3, HI=1.
- MTHI 0x12345678, then DIV by 0: after 10 busy cycles HI=0x12345678 and LO is unchanged. Then DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Start MULT 5×6, then during busy issue MTLO 0xDEAD and MULT 9×9 while toggling SRCA: both are ignored, and the final LO=30. The next-cycle `start` is accepted immediately after `busy` falls.
- Assert `reset` low in busy cycle 3 of a DIV after HI/LO had been written to 0x1/0x2: HI=LO=0 and `busy`=0 immediately, with no later commit. MFHI then gives `MDUresult`=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the FSM state type.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef logic [0:0] mdu_state_t;
   localparam mdu_state_t IDLE = 1'b0;
   localparam mdu_state_t RUN  = 1'b1;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_start_op(input logic [3:0] op);
      return is_mul_op(op) || is_div_op(op);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including
// divide-by-zero detection and the signed-overflow quotient.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [31:0] SRCA,
   input  logic [31:0] SRCB,
   input  logic [3:0]  MDUop,
   output logic [31:0] hi_next,
   output logic [31:0] lo_next,
   output logic        div_zero
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        divisor;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;
   logic [31:0]        mag_q;
   logic [31:0]        mag_r;
   logic [31:0]        quot_s;
   logic [31:0]        rem_s;
   logic [31:0]        quot_u;
   logic [31:0]        rem_u;

   assign a_ext  = {{32{SRCA[31]}}, SRCA};
   assign b_ext  = {{32{SRCB[31]}}, SRCB};
   assign prod_s = a_ext * b_ext;
   assign prod_u = {32'd0, SRCA} * {32'd0, SRCB};

   // A zero divisor is replaced by 1 so the dividers never see X; the result
   // is discarded anyway because div_zero suppresses the commit.
   assign divisor = (SRCB == 32'd0) ? 32'd1 : SRCB;

   // Signed divide on magnitudes. 0x80000000 / -1 falls out naturally: the
   // magnitude quotient 0x80000000 negates to itself with a zero remainder.
   assign abs_a  = SRCA[31] ? (~SRCA + 32'd1) : SRCA;
   assign abs_b  = divisor[31] ? (~divisor + 32'd1) : divisor;
   assign mag_q  = abs_a / abs_b;
   assign mag_r  = abs_a % abs_b;
   assign quot_s = (SRCA[31] ^ divisor[31]) ? (~mag_q + 32'd1) : mag_q;
   assign rem_s  = SRCA[31] ? (~mag_r + 32'd1) : mag_r;

   assign quot_u = SRCA / divisor;
   assign rem_u  = SRCA % divisor;

   always_comb begin
      hi_next  = 32'd0;
      lo_next  = 32'd0;
      div_zero = 1'b0;
      case (MDUop)
         OP_MULT: begin
            hi_next = prod_s[63:32];
            lo_next = prod_s[31:0];
         end
         OP_MULTU: begin
            hi_next = prod_u[63:32];
            lo_next = prod_u[31:0];
         end
         OP_DIV: begin
            hi_next  = rem_s;
            lo_next  = quot_s;
            div_zero = (SRCB == 32'd0);
         end
         OP_DIVU: begin
            hi_next  = rem_u;
            lo_next  = quot_u;
            div_zero = (SRCB == 32'd0);
         end
         default: begin
            hi_next  = 32'd0;
            lo_next  = 32'd0;
            div_zero = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: latches results on accept, counts the
// fixed latency, then commits HI/LO; busy drives the hazard unit's stall.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  MDUop,
   input  logic [31:0] SRCA,
   input  logic [31:0] SRCB,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUresult
);

   localparam int CNT_W = 16;

   mdu_state_t       state;
   logic [CNT_W-1:0] count;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_skip;
   logic [31:0]      hi_next;
   logic [31:0]      lo_next;
   logic             div_zero;

   mdu_calc u_calc (
      .SRCA     (SRCA),
      .SRCB     (SRCB),
      .MDUop    (MDUop),
      .hi_next  (hi_next),
      .lo_next  (lo_next),
      .div_zero (div_zero)
   );

   assign busy  = (state == RUN);
   assign start = req && is_start_op(MDUop) && !busy;

   always_comb begin
      MDUresult = 32'd0;
      if (MDUop == OP_MFHI) begin
         MDUresult = HI;
      end else if (MDUop == OP_MFLO) begin
         MDUresult = LO;
      end
   end

   // Results are captured on the accept edge so operand changes while the
   // op is in flight cannot disturb them; requests during RUN are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_skip <= 1'b0;
         HI        <= 32'd0;
         LO        <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pend_hi   <= hi_next;
                  pend_lo   <= lo_next;
                  pend_skip <= div_zero;
                  count     <= is_mul_op(MDUop) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state     <= RUN;
               end else if (req && (MDUop == OP_MTHI)) begin
                  HI <= SRCA;
               end else if (req && (MDUop == OP_MTLO)) begin
                  LO <= SRCA;
               end
            end
            RUN: begin
               if (count <= CNT_W'(1)) begin
                  if (!pend_skip) begin
                     HI <= pend_hi;
                     LO <= pend_lo;
                  end
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
